dds_wave_core: RTL and testbench
================================

DDS_WAVE_CORE -- requirements
Module: dds_wave_core

Interface
REQ-001 Parameter DW, 14, DAC sample and phase-accumulator width.
REQ-002 Parameter DIVW, 8, sample-rate divider width.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port en  input  1  generator enable.
REQ-006 Port wave_sel  input  2  waveform: 00 saw, 01 square, 10 inverted saw, 11 MSB square.
REQ-007 Port div  input  DIVW  sample-tick divider; one tick every div+1 clk cycles.
REQ-008 Port phase_inc  input  DW  phase step added per tick.
REQ-009 Port duty  input  DW  square-wave threshold.
REQ-010 Port da_data  output  DW  registered DAC sample.
REQ-011 Port da_clk  output  1  registered one-cycle DAC latch strobe.
REQ-012 Port da_wr  output  1  DAC write strobe; always the inverse of da_clk.

Function
REQ-013 Divider counter counts 0..div, then wraps to 0. The cycle where the count equals div asserts internal tick. div=0 gives a tick every cycle.
REQ-014 If div is lowered below the current count, the counter wraps to 0 on the next cycle and asserts no tick on that cycle.
REQ-015 On tick with en=1: phase <= phase + phase_inc, modulo 2^DW. Overflow wraps silently with no flag.
REQ-016 On tick with en=1: da_data <= waveform(wave_sel, pre-update phase). Latency from phase value to da_data is one clk cycle.
REQ-017 Waveforms, evaluated on the pre-update phase:
- Saw = phase.
- Square = 14'h3FFF if phase < duty, else 14'h0000.
- Inverted saw = 14'h3FFF - phase.
- MSB square = {phase[DW-1], 13'b0}.
REQ-018 duty=0 gives a constant 0 square output. duty=14'h2000 gives a 50% square output. Square never produces a full-high output for every phase.
REQ-019 With en=0: phase is cleared to 0 on the next clk edge, and da_data is loaded with midscale 14'h2000 on the next tick.
REQ-020 en rising: the first enabled tick outputs waveform(phase=0).
REQ-021 da_clk <= tick & en, so it is high for exactly one cycle per enabled sample. It is 0 when en=0.
REQ-022 On non-tick cycles, da_data and phase hold their values.
REQ-023 wave_sel, duty and phase_inc are sampled only on tick cycles. Changes take effect at the next tick with no glitch.

Reset
REQ-024 While rst_n=0 at a clk edge:
- divider counter <= 0;
- phase <= 0;
- da_data <= 14'h2000;
- da_clk <= 0, so da_wr = 1.
REQ-025 Reset overrides en and tick on the same edge. Reset asserted mid-waveform discards the phase.
REQ-026 After rst_n is released, the first tick occurs div+1 cycles later.

Structure
REQ-027 A shared package holds DW, DIVW, the wave_sel encodings (WAVE_SAW, WAVE_SQR, WAVE_ISAW, WAVE_MSB) and the MIDSCALE constant 14'h2000.
REQ-028 The divider/tick generator is a single sub-module, tick_div. The phase accumulator and waveform mux stay in dds_wave_core.

Verification
REQ-029 Reset then div=0, phase_inc=1, wave_sel=00, en=1:
- da_data = 0,1,2,... one per cycle;
- wraps 3FFF->0000 after 16384 ticks;
- da_clk high every cycle.
REQ-030 div=3, phase_inc=14'h0400, saw:
- da_clk pulses every 4th cycle;
- da_data steps 0000,0400,0800,... wrapping after 16 ticks.
REQ-031 wave_sel=01, duty=14'h2000, phase_inc=14'h1000:
- pattern 3FFF x2, 0000 x2, repeating;
- duty=0 gives constant 0000.
REQ-032 wave_sel=10, phase_inc=1, div=0: da_data = 3FFF, 3FFE, 3FFD, ...
REQ-033 Mid-run en=0:
- da_data becomes 2000 on the next tick;
- da_clk stays low;
- on re-enable, the first sample is waveform(0), e.g. 0000 for saw.
REQ-034 rst_n low for 1 cycle mid-run:
- outputs are da_data=2000, da_clk=0, da_wr=1 on the following cycle;
- the first post-reset tick comes after div+1 cycles.

Source files
------------

// File: rtl/dds_wave_core_pkg.sv
// Shared constants and wave_sel encodings for the DDS waveform core.
// The default widths of the core and its tick divider are taken from here.
package dds_wave_core_pkg;

    localparam int DW   = 14;
    localparam int DIVW = 8;

    typedef enum logic [1:0] {
        WAVE_SAW  = 2'b00,
        WAVE_SQR  = 2'b01,
        WAVE_ISAW = 2'b10,
        WAVE_MSB  = 2'b11
    } wave_e;

    localparam logic [DW-1:0] MIDSCALE = 14'h2000;

endpackage

// File: rtl/dds_wave_core_tick_div.sv
// Sample-rate divider: counts 0..div and emits a one-cycle tick when the count equals div.
// If div drops below the count, the counter restarts at 0 without producing a tick.
module tick_div #(
    parameter int DIVW = dds_wave_core_pkg::DIVW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DIVW-1:0] div,
    output logic            tick
);

    logic [DIVW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == div);
        cnt_d = (cnt_q >= div) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dds_wave_core.sv
// DDS waveform core: a phase accumulator advanced on divider ticks, feeding a four-way waveform mux.
// The output is a registered DAC sample, latched by a one-cycle da_clk strobe.
module dds_wave_core #(
    parameter int DW   = dds_wave_core_pkg::DW,
    parameter int DIVW = dds_wave_core_pkg::DIVW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [1:0]      wave_sel,
    input  logic [DIVW-1:0] div,
    input  logic [DW-1:0]   phase_inc,
    input  logic [DW-1:0]   duty,
    output logic [DW-1:0]   da_data,
    output logic            da_clk,
    output logic            da_wr
);

    import dds_wave_core_pkg::*;

    localparam logic [DW-1:0] MID = DW'(MIDSCALE);

    logic          tick;
    logic [DW-1:0] phase_q, phase_d;
    logic [DW-1:0] da_data_q, da_data_d;
    logic          da_clk_q, da_clk_d;
    logic [DW-1:0] wave_val;

    tick_div #(.DIVW(DIVW)) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .div   (div),
        .tick  (tick)
    );

    // Waveform is taken from the pre-update phase, so the sample lags the accumulator by one tick.
    always_comb begin
        wave_val = phase_q;
        case (wave_e'(wave_sel))
            WAVE_SAW:  wave_val = phase_q;
            WAVE_SQR:  wave_val = (phase_q < duty) ? '1 : '0;
            WAVE_ISAW: wave_val = '1 - phase_q;
            WAVE_MSB:  wave_val = {phase_q[DW-1], {(DW-1){1'b0}}};
            default:   wave_val = phase_q;
        endcase
    end

    always_comb begin
        phase_d   = phase_q;
        da_data_d = da_data_q;
        da_clk_d  = tick & en;
        if (!en) begin
            phase_d = '0;
            if (tick) da_data_d = MID;
        end else if (tick) begin
            phase_d   = phase_q + phase_inc;
            da_data_d = wave_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= '0;
            da_data_q <= MID;
            da_clk_q  <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            da_data_q <= da_data_d;
            da_clk_q  <= da_clk_d;
        end
    end

    assign da_data = da_data_q;
    assign da_clk  = da_clk_q;
    assign da_wr   = ~da_clk_q;

endmodule

// File: tb/tb_dds_wave_core.sv
// Scoreboard bench for dds_wave_core: stimulus pushes per-edge expectations from an arithmetic
// reference model, and a negedge monitor pops them and compares them with the DUT outputs.
module tb_dds_wave_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  wave_sel = 2'b00;
    logic [7:0]  div = 8'd0;
    logic [13:0] phase_inc = 14'd0;
    logic [13:0] duty = 14'd0;
    logic [13:0] da_data;
    logic        da_clk;
    logic        da_wr;

    dds_wave_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .wave_sel  (wave_sel),
        .div       (div),
        .phase_inc (phase_inc),
        .duty      (duty),
        .da_data   (da_data),
        .da_clk    (da_clk),
        .da_wr     (da_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        int       data;
        bit       dclk;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: divider position, phase as an integer mod 16384, last DAC sample and strobe.
    int m_cnt = 0, m_ph = 0, m_data = 8192;
    bit m_clk = 1'b0;

    function automatic int wave_ref(int sel, int ph, int dt);
        case (sel)
            0: return ph;
            1: return (ph < dt) ? 16383 : 0;
            2: return 16383 - ph;
            default: return (ph >= 8192) ? 8192 : 0;
        endcase
    endfunction

    task automatic model_edge();
        bit tk;
        exp_t e;
        if (!rst_n) begin
            m_cnt = 0; m_ph = 0; m_data = 8192; m_clk = 1'b0;
        end else begin
            tk = (m_cnt == int'(div));
            if (tk || m_cnt > int'(div)) m_cnt = 0;
            else m_cnt = m_cnt + 1;
            m_clk = tk && en;
            if (!en) begin
                if (tk) m_data = 8192;
                m_ph = 0;
            end else if (tk) begin
                m_data = wave_ref(int'(wave_sel), m_ph, int'(duty));
                m_ph = (m_ph + int'(phase_inc)) % 16384;
            end
        end
        e.cyc = cyc + 1; e.data = m_data; e.dclk = m_clk;
        q.push_back(e);
    endtask

    // Called at posedge+#1 with inputs already set; each iteration covers one upcoming edge.
    task automatic run(input int n);
        repeat (n) begin
            model_edge();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input bit r, input bit e, input logic [1:0] ws, input logic [7:0] d,
                       input logic [13:0] inc, input logic [13:0] dt);
        rst_n = r; en = e; wave_sel = ws; div = d; phase_inc = inc; duty = dt;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
            errors++; checks++;
            $display("FAIL stale_expect cyc=%0d got=none exp_cyc=%0d", cyc, q[0].cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            checks += 3;
            if (int'(da_data) != e.data) begin
                errors++;
                $display("FAIL da_data cyc=%0d got=%h exp=%h", cyc, da_data, e.data[13:0]);
            end
            if (da_clk !== e.dclk) begin
                errors++;
                $display("FAIL da_clk cyc=%0d got=%b exp=%b", cyc, da_clk, e.dclk);
            end
            if (da_wr !== !e.dclk) begin
                errors++;
                $display("FAIL da_wr cyc=%0d got=%b exp=%b", cyc, da_wr, !e.dclk);
            end
        end
    end

    initial begin
        int len;
        @(posedge clk); #1;
        // Reset, then free-running saw at div=0 past a full 16384-tick wrap.
        cfg(0, 1, 2'b00, 8'd0, 14'd1, 14'd0);       run(3);
        cfg(1, 1, 2'b00, 8'd0, 14'd1, 14'd0);       run(16400);
        // Divided saw with coarse step.
        cfg(0, 0, 2'b00, 8'd3, 14'h0400, 14'd0);    run(1);
        cfg(1, 1, 2'b00, 8'd3, 14'h0400, 14'd0);    run(80);
        // 50% square, then duty=0.
        cfg(0, 0, 2'b01, 8'd0, 14'h1000, 14'h2000); run(1);
        cfg(1, 1, 2'b01, 8'd0, 14'h1000, 14'h2000); run(20);
        cfg(1, 1, 2'b01, 8'd0, 14'h1000, 14'h0000); run(10);
        // Inverted saw.
        cfg(0, 0, 2'b10, 8'd0, 14'd1, 14'd0);       run(1);
        cfg(1, 1, 2'b10, 8'd0, 14'd1, 14'd0);       run(20);
        // MSB square with large step.
        cfg(1, 1, 2'b11, 8'd1, 14'h0C00, 14'd0);    run(40);
        // Mid-run disable and re-enable.
        cfg(1, 1, 2'b00, 8'd2, 14'h0123, 14'd0);    run(20);
        cfg(1, 0, 2'b00, 8'd2, 14'h0123, 14'd0);    run(10);
        cfg(1, 1, 2'b00, 8'd2, 14'h0123, 14'd0);    run(20);
        // One-cycle reset mid-run at div=4.
        cfg(0, 1, 2'b00, 8'd4, 14'h0111, 14'd0);    run(1);
        cfg(1, 1, 2'b00, 8'd4, 14'h0111, 14'd0);    run(25);
        // Lower div below the current count.
        cfg(1, 1, 2'b00, 8'd9, 14'h0040, 14'd0);    run(16);
        cfg(1, 1, 2'b00, 8'd1, 14'h0040, 14'd0);    run(12);
        // Randomized segments.
        for (int s = 0; s < 200; s++) begin
            len = $urandom_range(1, 40);
            cfg(($urandom % 25) != 0, ($urandom % 6) != 0, 2'($urandom),
                ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)),
                14'($urandom), ($urandom % 5 == 0) ? 14'd0 : 14'($urandom));
            run(len);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
